keypad_scan_ctrl: RTL and testbench

Sequencing controller for the 3x4 keypad peripheral on the RAT I/O bus. It drives the row strobes, samples the columns, debounces the decoded key and latches a 4-bit key code. It raises a fixed-width interrupt pulse per new key and holds a valid flag until the CPU acknowledges it. It sits between the keypad pins and the RAT input port / interrupt line.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_scan_ctrl_if.sv | 35 +++
 rtl/key_int_pulse.sv | 47 ++++
 rtl/keypad_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, state types and the row/column keymap for the 3x4 keypad controller.
package keypad_pkg;

    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    typedef enum logic {StDrive, StEval} scan_state_e;
    typedef enum logic {StIdle, StPulse} int_state_e;

    // Row-major: rows 0..2 hold digits 1..9, row 3 holds *, 0, #.
    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = KEY_NONE;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pins and CPU-side key/interrupt signals of the keypad scan controller.
interface keypad_scan_ctrl_if;

    logic [2:0] col;
    logic       int_ack;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       overrun;
    logic       interrupt;

    modport master (
        input  col,
        input  int_ack,
        output row,
        output key_code,
        output key_valid,
        output key_down,
        output overrun,
        output interrupt
    );

    modport slave (
        output col,
        output int_ack,
        input  row,
        input  key_code,
        input  key_valid,
        input  key_down,
        input  overrun,
        input  interrupt
    );

endinterface

// File: rtl/key_int_pulse.sv
// Fixed-width interrupt pulse generator; a start while pulsing restarts the width count.
module key_int_pulse
    import keypad_pkg::*;
#(
    parameter int unsigned INT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic pulse_o
);

    localparam int unsigned CntW = (INT_CYCLES > 1) ? $clog2(INT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(INT_CYCLES - 1);

    int_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            state_d = StPulse;
            cnt_d   = '0;
        end else if (state_q == StPulse) begin
            if (cnt_q == CntLast) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign pulse_o = (state_q == StPulse);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-scanning keypad controller: frame sampling, debounce, key latch and CPU handshake.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned INT_CYCLES     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    keypad_scan_ctrl_if.master bus
);

    localparam int unsigned DwellW  = $clog2(SCAN_DIV);
    localparam int unsigned StableW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DwellW-1:0]  DwellLast = DwellW'(SCAN_DIV - 1);
    localparam logic [StableW-1:0] StableMax = StableW'(DEBOUNCE_SCANS);

    scan_state_e        state_q, state_d;
    logic [1:0]         row_idx_q, row_idx_d;
    logic [DwellW-1:0]  dwell_q, dwell_d;
    logic [3:0]         frame_q, frame_d;
    logic [3:0]         cand_q, cand_d;
    logic [3:0]         committed_q, committed_d;
    logic [StableW-1:0] stable_q, stable_d;
    logic [3:0]         key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;
    logic               key_down_q, key_down_d;
    logic               overrun_q, overrun_d;
    logic               commit_press;
    logic [1:0]         col_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StDrive;
            row_idx_q   <= 2'd0;
            dwell_q     <= '0;
            frame_q     <= KEY_NONE;
            cand_q      <= KEY_NONE;
            committed_q <= KEY_NONE;
            stable_q    <= '0;
            key_code_q  <= KEY_NONE;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            dwell_q     <= dwell_d;
            frame_q     <= frame_d;
            cand_q      <= cand_d;
            committed_q <= committed_d;
            stable_q    <= stable_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            overrun_q   <= overrun_d;
        end
    end

    // Lowest pressed column wins within a row.
    always_comb begin
        col_idx = 2'd2;
        if (bus.col[0]) begin
            col_idx = 2'd0;
        end else if (bus.col[1]) begin
            col_idx = 2'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_idx_d    = row_idx_q;
        dwell_d      = dwell_q;
        frame_d      = frame_q;
        cand_d       = cand_q;
        committed_d  = committed_q;
        stable_d     = stable_q;
        key_code_d   = key_code_q;
        key_valid_d  = key_valid_q;
        key_down_d   = key_down_q;
        overrun_d    = overrun_q;
        commit_press = 1'b0;

        // A same-cycle press commit below overrides this clear.
        if (bus.int_ack) begin
            key_valid_d = 1'b0;
        end

        case (state_q)
            StDrive: begin
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    if (frame_q == KEY_NONE && |bus.col) begin
                        frame_d = keymap(row_idx_q, col_idx);
                    end
                    if (row_idx_q == 2'd3) begin
                        state_d = StEval;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            StEval: begin
                if (frame_q == cand_q) begin
                    if (stable_q != StableMax) begin
                        stable_d = stable_q + 1'b1;
                    end
                end else begin
                    cand_d   = frame_q;
                    stable_d = StableW'(1);
                end
                if (stable_d == StableMax && cand_d != committed_q) begin
                    committed_d = cand_d;
                    if (cand_d == KEY_NONE) begin
                        key_down_d = 1'b0;
                    end else begin
                        key_code_d   = cand_d;
                        key_down_d   = 1'b1;
                        key_valid_d  = 1'b1;
                        commit_press = 1'b1;
                        // An ack in the commit cycle retires the old key, so no overrun.
                        if (key_valid_q && !bus.int_ack) begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                row_idx_d = 2'd0;
                frame_d   = KEY_NONE;
                state_d   = StDrive;
            end
            default: state_d = StDrive;
        endcase
    end

    assign bus.row       = 4'b0001 << row_idx_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_down  = key_down_q;
    assign bus.overrun   = overrun_q;

    key_int_pulse #(
        .INT_CYCLES(INT_CYCLES)
    ) u_int_pulse (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(commit_press),
        .pulse_o(bus.interrupt)
    );

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench: keypad model drives columns, a frame-level reference model checks outputs.
module tb_keypad_scan_ctrl;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 2;
    localparam int unsigned INTC     = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ack   = 1'b0;
    logic [11:0] pressed = '0;   // bit index = row*3 + col
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    logic [3:0] code_of [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                 4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};

    // Reference model state
    int         m_phase;
    int         m_stable;
    int         m_int_left;
    logic [3:0] m_frame, m_cand, m_committed, m_code;
    logic       m_valid, m_down, m_ovr;

    keypad_scan_ctrl_if bus ();

    keypad_scan_ctrl #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB),
        .INT_CYCLES    (INTC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.int_ack = ack;

    always_comb begin
        bus.col = 3'b000;
        for (int r = 0; r < 4; r++) begin
            if (bus.row[r]) bus.col = bus.col | pressed[r*3 +: 3];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_stable = 0; m_int_left = 0;
        m_frame = 4'hF; m_cand = 4'hF; m_committed = 4'hF; m_code = 4'hF;
        m_valid = 1'b0; m_down = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_step();
        bit press;
        int r;
        press = 1'b0;
        if (m_int_left > 0) m_int_left--;
        if (m_phase < 4 * SCAN_DIV) begin
            r = m_phase / SCAN_DIV;
            if (m_phase % SCAN_DIV == SCAN_DIV - 1) begin
                for (int c = 0; c < 3; c++) begin
                    if (pressed[r*3+c] && m_frame == 4'hF) m_frame = code_of[r*3+c];
                end
            end
            m_phase++;
        end else begin
            if (m_frame == m_cand) begin
                if (m_stable < DEB) m_stable++;
            end else begin
                m_cand = m_frame;
                m_stable = 1;
            end
            if (m_stable == DEB && m_cand != m_committed) begin
                m_committed = m_cand;
                if (m_cand == 4'hF) begin
                    m_down = 1'b0;
                end else begin
                    if (m_valid && !ack) m_ovr = 1'b1;
                    m_code = m_cand;
                    m_down = 1'b1;
                    m_valid = 1'b1;
                    m_int_left = INTC;
                    press = 1'b1;
                end
            end
            m_frame = 4'hF;
            m_phase = 0;
        end
        if (ack && !press) m_valid = 1'b0;
    endtask

    // Per-cycle comparison against the model.
    initial begin
        logic [3:0] exp_row;
        model_reset();
        forever begin
            @(posedge clk);
            if (rst_n) model_step();
            @(negedge clk);
            if (!rst_n) model_reset();
            exp_row = (m_phase < 4 * SCAN_DIV) ? (4'b0001 << (m_phase / SCAN_DIV)) : 4'b1000;
            chk("row", bus.row, exp_row);
            chk("key_code", bus.key_code, m_code);
            chk("key_valid", bus.key_valid, m_valid);
            chk("key_down", bus.key_down, m_down);
            chk("overrun", bus.overrun, m_ovr);
            chk("interrupt", bus.interrupt, m_int_left > 0);
        end
    end

    task automatic go_to(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Called at a negedge: asserts reset mid-cycle, checks it took effect at once, releases.
    task automatic do_reset(input string name);
        #2 rst_n = 1'b0;
        #1 chk(name, {bus.row, bus.key_code, bus.key_valid, bus.key_down, bus.overrun,
                      bus.interrupt}, {4'b0001, 4'hF, 4'b0000});
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        @(negedge clk);
        do_reset("reset_initial");

        // Idle scan
        go_to(5);  chk("row_phase5", bus.row, 4'b0010);
        go_to(16); chk("row_eval", bus.row, 4'b1000);
        go_to(17); chk("row_wrap", bus.row, 4'b0001);

        // Key 5 press, commit after the second EVAL
        pressed = 12'b1 << 4;
        do_reset("reset_before_5");
        go_to(33); chk("int_before_commit", bus.interrupt, 1'b0);
        go_to(34);
        chk("int_at_commit", bus.interrupt, 1'b1);
        chk("code_5", bus.key_code, 4'h5);
        chk("valid_5", bus.key_valid, 1'b1);
        chk("model_code_5", m_code, 4'h5);
        go_to(36); chk("int_last", bus.interrupt, 1'b1);
        go_to(37); chk("int_end", bus.interrupt, 1'b0);
        go_to(51); pressed = '0;
        go_to(85);
        chk("down_released", bus.key_down, 1'b0);
        chk("code_holds", bus.key_code, 4'h5);

        // Key 8 with ack in its commit cycle: valid stays, no overrun
        pressed = 12'b1 << 7;
        go_to(118); ack = 1'b1;
        go_to(119); ack = 1'b0;
        chk("code_8", bus.key_code, 4'h8);
        chk("valid_ack_commit", bus.key_valid, 1'b1);
        chk("ovr_ack_commit", bus.overrun, 1'b0);
        pressed = '0;
        go_to(153); pressed = 12'b1 << 10;
        go_to(187);
        chk("code_0", bus.key_code, 4'h0);
        chk("overrun_set", bus.overrun, 1'b1);
        chk("int_second", bus.interrupt, 1'b1);
        chk("model_ovr", m_ovr, 1'b1);

        // Bounce on '#' for one frame
        pressed = 12'b1 << 11;
        go_to(188);
        do_reset("reset_before_bounce");
        go_to(17); pressed = '0;
        go_to(51);
        chk("bounce_code", bus.key_code, 4'hF);
        chk("bounce_valid", bus.key_valid, 1'b0);

        // '*' and '#' together: lowest column wins
        pressed = (12'b1 << 9) | (12'b1 << 11);
        go_to(85); chk("code_star", bus.key_code, 4'hA);

        // Reset mid-dwell of row 2, then during a pulse
        go_to(94); chk("row2_pre_reset", bus.row, 4'b0100);
        do_reset("reset_row2");
        go_to(35); chk("int_pre_reset", bus.interrupt, 1'b1);
        do_reset("reset_in_pulse");
        go_to(1); chk("row_after_reset", bus.row, 4'b0001);

        // Randomised presses and acks
        for (int ev = 0; ev < 40; ev++) begin
            int sel, hold;
            sel = $urandom_range(0, 3);
            if (sel == 0) pressed = '0;
            else if (sel == 1) pressed = 12'b1 << $urandom_range(0, 11);
            else if (sel == 2) pressed = (12'b1 << $urandom_range(0, 11)) |
                                         (12'b1 << $urandom_range(0, 11));
            hold = $urandom_range(5, 70);
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                ack = ($urandom_range(0, 15) == 0);
            end
        end
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
